f_rob: RTL

- FPU reorder buffer. Sits between FRename/FPU writeback and the FPU physical register file (PRF).
- Records each renamed FP instruction in program order and marks it done on FPU completion.
- Retires entries in order by driving the PRF commit interface (fpr_wen0/1, fpr_waddr, fpr_wprf0/1).
- Drives the PRF flush, either on a retiring exception or on an external pipeline flush.

---
 rtl/f_rob.sv | 120 ++++++++++++
 1 files changed

// File: rtl/f_rob.sv
// FPU reorder buffer: records renamed FP instructions in order, retires the head into the PRF.
// Latency: a completion registered at edge N can retire in the cycle after N; commit/flush are combinational.
// Backpressure: alloc_ready drops at DEPTH entries, regardless of a commit in the same cycle.
module f_rob #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_in,
    input  logic             alloc_valid,
    input  logic             alloc_wen0,
    input  logic             alloc_wen1,
    input  logic [3:0]       alloc_waddr,
    input  logic [4:0]       alloc_prf0,
    input  logic [4:0]       alloc_prf1,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             cmpl_valid,
    input  logic [IDX_W-1:0] cmpl_idx,
    input  logic             cmpl_except,
    output logic             fpr_wen0,
    output logic             fpr_wen1,
    output logic [3:0]       fpr_waddr,
    output logic [4:0]       fpr_wprf0,
    output logic [4:0]       fpr_wprf1,
    output logic             commit_valid,
    output logic             flush,
    output logic             exc_valid
);

    typedef struct packed {
        logic       wen0;
        logic       wen1;
        logic [3:0] waddr;
        logic [4:0] prf0;
        logic [4:0] prf1;
    } ent_t;

    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    ent_t             ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] exc_q;
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [IDX_W:0]   cnt_q;

    ent_t head_ent;
    logic ret;
    logic exc;
    logic alloc_fire;
    logic cmpl_fire;

    assign head_ent   = ent_q[head_q];
    assign ret        = vld_q[head_q] & done_q[head_q] & ~exc_q[head_q];
    assign exc        = vld_q[head_q] & done_q[head_q] &  exc_q[head_q];
    assign flush      = flush_in | exc;
    assign alloc_ready = (cnt_q != CNT_FULL);
    assign alloc_idx  = tail_q;
    assign alloc_fire = alloc_valid & alloc_ready & ~flush;
    assign cmpl_fire  = cmpl_valid & vld_q[cmpl_idx] & ~flush;

    // A normal retire still commits alongside flush_in: the head is older than the flush cause.
    assign commit_valid = ret;
    assign fpr_wen0     = ret & head_ent.wen0;
    assign fpr_wen1     = ret & head_ent.wen1;
    assign fpr_waddr    = head_ent.waddr;
    assign fpr_wprf0    = head_ent.prf0;
    assign fpr_wprf1    = head_ent.prf1;
    assign exc_valid    = exc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q  <= '0;
            done_q <= '0;
            exc_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (ret) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + IDX_ONE;
            end
            if (alloc_fire) begin
                vld_q[tail_q]  <= 1'b1;
                done_q[tail_q] <= 1'b0;
                exc_q[tail_q]  <= 1'b0;
                tail_q         <= tail_q + IDX_ONE;
            end
            if (cmpl_fire) begin
                done_q[cmpl_idx] <= 1'b1;
                exc_q[cmpl_idx]  <= cmpl_except;
            end
            if (alloc_fire && !ret) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (ret && !alloc_fire) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid head.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_q[tail_q] <= '{wen0: alloc_wen0, wen1: alloc_wen1, waddr: alloc_waddr,
                               prf0: alloc_prf0, prf1: alloc_prf1};
        end
    end

endmodule
